// File: rtl/led_palette_scheduler_pkg.sv
// Shared types for the LED palette scheduler: FSM states, load selects
// and the LED-count/value widths shared with the pulser and PWM driver.
package led_palette_scheduler_pkg;

    localparam int LED_VALUE_W     = 8;
    localparam int COLOR_LED_COUNT = 4;
    localparam int BASIC_LED_COUNT = 4;
    localparam int BLANK_CNT_W     = 8;
    localparam int HOLD_CNT_W      = 16;

    typedef enum logic [1:0] {
        S_BASE,
        S_BLANK_TO_OVR,
        S_OVR,
        S_BLANK_TO_BASE
    } t_palette_sched_state;

    typedef enum logic [1:0] {
        LOAD_ZERO,
        LOAD_BASE,
        LOAD_OVR
    } t_palette_load_sel;

endpackage

// File: rtl/led_palette_scheduler_if.sv
// Override requester bus: level request, grant back, override palette.
// master = alert/fault requester, slave = palette scheduler.
interface led_palette_scheduler_if
    import led_palette_scheduler_pkg::*;
#(
    parameter int parm_color_led_count = COLOR_LED_COUNT,
    parameter int parm_basic_led_count = BASIC_LED_COUNT
);
    localparam int CW = LED_VALUE_W * parm_color_led_count;
    localparam int BW = LED_VALUE_W * parm_basic_led_count;

    logic          ovr_req;
    logic          ovr_gnt;
    logic [CW-1:0] ovr_red_value;
    logic [CW-1:0] ovr_green_value;
    logic [CW-1:0] ovr_blue_value;
    logic [BW-1:0] ovr_lumin_value;

    modport master (
        output ovr_req,
        output ovr_red_value,
        output ovr_green_value,
        output ovr_blue_value,
        output ovr_lumin_value,
        input  ovr_gnt
    );

    modport slave (
        input  ovr_req,
        input  ovr_red_value,
        input  ovr_green_value,
        input  ovr_blue_value,
        input  ovr_lumin_value,
        output ovr_gnt
    );

endinterface

// File: rtl/led_palette_frame_latch.sv
// Registered palette bank: on i_load takes base, override or zeros
// (zeros also when display disabled) and pulses o_frame_load.
module led_palette_frame_latch
    import led_palette_scheduler_pkg::*;
#(
    parameter int  parm_color_led_count = COLOR_LED_COUNT,
    parameter int  parm_basic_led_count = BASIC_LED_COUNT,
    localparam int CW = LED_VALUE_W * parm_color_led_count,
    localparam int BW = LED_VALUE_W * parm_basic_led_count
) (
    input  logic              i_clk,
    input  logic              i_arst,
    input  logic              i_load,
    input  t_palette_load_sel i_sel,
    input  logic              i_display_enable,
    input  logic [CW-1:0]     i_base_red_value,
    input  logic [CW-1:0]     i_base_green_value,
    input  logic [CW-1:0]     i_base_blue_value,
    input  logic [BW-1:0]     i_base_lumin_value,
    input  logic [CW-1:0]     i_ovr_red_value,
    input  logic [CW-1:0]     i_ovr_green_value,
    input  logic [CW-1:0]     i_ovr_blue_value,
    input  logic [BW-1:0]     i_ovr_lumin_value,
    output logic [CW-1:0]     o_color_led_red_value,
    output logic [CW-1:0]     o_color_led_green_value,
    output logic [CW-1:0]     o_color_led_blue_value,
    output logic [BW-1:0]     o_basic_led_lumin_value,
    output logic              o_frame_load
);

    logic [CW-1:0] nxt_red;
    logic [CW-1:0] nxt_green;
    logic [CW-1:0] nxt_blue;
    logic [BW-1:0] nxt_lumin;

    always_comb begin
        nxt_red   = '0;
        nxt_green = '0;
        nxt_blue  = '0;
        nxt_lumin = '0;
        if (i_display_enable) begin
            case (i_sel)
                LOAD_BASE: begin
                    nxt_red   = i_base_red_value;
                    nxt_green = i_base_green_value;
                    nxt_blue  = i_base_blue_value;
                    nxt_lumin = i_base_lumin_value;
                end
                LOAD_OVR: begin
                    nxt_red   = i_ovr_red_value;
                    nxt_green = i_ovr_green_value;
                    nxt_blue  = i_ovr_blue_value;
                    nxt_lumin = i_ovr_lumin_value;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_color_led_red_value   <= '0;
            o_color_led_green_value <= '0;
            o_color_led_blue_value  <= '0;
            o_basic_led_lumin_value <= '0;
            o_frame_load            <= 1'b0;
        end else begin
            o_frame_load <= i_load;
            if (i_load) begin
                o_color_led_red_value   <= nxt_red;
                o_color_led_green_value <= nxt_green;
                o_color_led_blue_value  <= nxt_blue;
                o_basic_led_lumin_value <= nxt_lumin;
            end
        end
    end

endmodule

// File: rtl/led_palette_scheduler.sv
// Period-boundary arbiter between base and override palettes with dark
// blanking on every source switch and a minimum override hold.
// Ports: i_clk, i_arst, i_pwm_period_end, i_display_enable, base palette,
// ovr_bus (override requester), registered palette out, o_frame_load.
module led_palette_scheduler
    import led_palette_scheduler_pkg::*;
#(
    parameter int  parm_color_led_count  = COLOR_LED_COUNT,
    parameter int  parm_basic_led_count  = BASIC_LED_COUNT,
    parameter int  parm_blank_periods    = 2,
    parameter int  parm_min_hold_periods = 16,
    localparam int CW = LED_VALUE_W * parm_color_led_count,
    localparam int BW = LED_VALUE_W * parm_basic_led_count
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_pwm_period_end,
    input  logic                   i_display_enable,
    input  logic [CW-1:0]          i_base_red_value,
    input  logic [CW-1:0]          i_base_green_value,
    input  logic [CW-1:0]          i_base_blue_value,
    input  logic [BW-1:0]          i_base_lumin_value,
    led_palette_scheduler_if.slave ovr_bus,
    output logic [CW-1:0]          o_color_led_red_value,
    output logic [CW-1:0]          o_color_led_green_value,
    output logic [CW-1:0]          o_color_led_blue_value,
    output logic [BW-1:0]          o_basic_led_lumin_value,
    output logic                   o_frame_load
);

    localparam bit BLANK_EN = (parm_blank_periods > 0);
    localparam logic [BLANK_CNT_W-1:0] BLANK_INIT =
        BLANK_CNT_W'(BLANK_EN ? parm_blank_periods - 1 : 0);
    localparam logic [HOLD_CNT_W-1:0] HOLD_INIT =
        HOLD_CNT_W'(parm_min_hold_periods > 0 ? parm_min_hold_periods - 1 : 0);

    t_palette_sched_state    state, state_nxt;
    logic [BLANK_CNT_W-1:0]  blank_cnt, blank_nxt;
    logic [HOLD_CNT_W-1:0]   hold_cnt, hold_nxt;
    logic                    load;
    t_palette_load_sel       sel;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state     <= S_BASE;
            blank_cnt <= '0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            blank_cnt <= blank_nxt;
            hold_cnt  <= hold_nxt;
        end
    end

    // Every period end reloads the outputs; only the source changes.
    always_comb begin
        state_nxt = state;
        blank_nxt = blank_cnt;
        hold_nxt  = hold_cnt;
        load      = 1'b0;
        sel       = LOAD_BASE;
        if (i_pwm_period_end) begin
            load = 1'b1;
            unique case (state)
                S_BASE: begin
                    if (ovr_bus.ovr_req && BLANK_EN) begin
                        sel       = LOAD_ZERO;
                        blank_nxt = BLANK_INIT;
                        state_nxt = S_BLANK_TO_OVR;
                    end else if (ovr_bus.ovr_req) begin
                        sel       = LOAD_OVR;
                        hold_nxt  = HOLD_INIT;
                        state_nxt = S_OVR;
                    end
                end
                S_BLANK_TO_OVR: begin
                    if (!ovr_bus.ovr_req) begin
                        state_nxt = S_BASE;
                    end else if (blank_cnt == '0) begin
                        sel       = LOAD_OVR;
                        hold_nxt  = HOLD_INIT;
                        state_nxt = S_OVR;
                    end else begin
                        sel       = LOAD_ZERO;
                        blank_nxt = blank_cnt - BLANK_CNT_W'(1);
                    end
                end
                S_OVR: begin
                    sel = LOAD_OVR;
                    if (hold_cnt != '0) begin
                        hold_nxt = hold_cnt - HOLD_CNT_W'(1);
                    end else if (ovr_bus.ovr_req) begin
                        sel = LOAD_OVR;
                    end else if (BLANK_EN) begin
                        sel       = LOAD_ZERO;
                        blank_nxt = BLANK_INIT;
                        state_nxt = S_BLANK_TO_BASE;
                    end else begin
                        sel       = LOAD_BASE;
                        state_nxt = S_BASE;
                    end
                end
                S_BLANK_TO_BASE: begin
                    if (blank_cnt == '0) begin
                        state_nxt = S_BASE;
                    end else begin
                        sel       = LOAD_ZERO;
                        blank_nxt = blank_cnt - BLANK_CNT_W'(1);
                    end
                end
                default: state_nxt = S_BASE;
            endcase
        end
    end

    // Grant follows the registered state, so it moves on the load edge.
    assign ovr_bus.ovr_gnt = (state == S_OVR);

    led_palette_frame_latch #(
        .parm_color_led_count (parm_color_led_count),
        .parm_basic_led_count (parm_basic_led_count)
    ) u_frame_latch (
        .i_clk                   (i_clk),
        .i_arst                  (i_arst),
        .i_load                  (load),
        .i_sel                   (sel),
        .i_display_enable        (i_display_enable),
        .i_base_red_value        (i_base_red_value),
        .i_base_green_value      (i_base_green_value),
        .i_base_blue_value       (i_base_blue_value),
        .i_base_lumin_value      (i_base_lumin_value),
        .i_ovr_red_value         (ovr_bus.ovr_red_value),
        .i_ovr_green_value       (ovr_bus.ovr_green_value),
        .i_ovr_blue_value        (ovr_bus.ovr_blue_value),
        .i_ovr_lumin_value       (ovr_bus.ovr_lumin_value),
        .o_color_led_red_value   (o_color_led_red_value),
        .o_color_led_green_value (o_color_led_green_value),
        .o_color_led_blue_value  (o_color_led_blue_value),
        .o_basic_led_lumin_value (o_basic_led_lumin_value),
        .o_frame_load            (o_frame_load)
    );

endmodule
